rom_loader: RTL
===============

Name: rom_loader

Overview:
- Hardware program loader: writes instruction ROM contents from a byte stream instead of a simulation-time file preload.
- Accepts a length-prefixed little-endian byte stream over a valid/ready interface.
- Assembles 32-bit words and issues one ROM write per word.
- Holds the CPU core in reset until the image is fully written, then releases it. Sits between a UART/debug byte source and the soc's ROM write port.

Parameters:
ADDR_WIDTH, 12, word-address width of ROM write port
DEPTH, 4096, ROM capacity in 32-bit words; must be <= 2**ADDR_WIDTH

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  begin a load session (sampled in IDLE/DONE/ERR)
in_valid  input  1  byte stream valid
in_data  input  8  byte stream data
in_ready  output  1  loader can accept a byte
rom_we  output  1  ROM write strobe, one cycle per word
rom_waddr  output  ADDR_WIDTH  ROM word address
rom_wdata  output  32  ROM write data
cpu_hold  output  1  hold CPU in reset while high
done  output  1  image loaded, CPU released
err  output  1  illegal length received

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0, cpu_hold=1, done=0, err=0.
- Byte accept: a byte is accepted on a rising edge where in_valid && in_ready. in_data must be ignored otherwise.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - start -> LEN. Byte counter and word counter clear; write address is set to 0.
- LEN:
  - in_ready=1.
  - Accept 4 bytes, assembled little-endian into a 32-bit word count N (first byte = bits 7:0).
  - On the 4th accepted byte:
    - N==0 or N>DEPTH -> ERR.
    - Otherwise -> DATA.
  - No ROM write occurs for length bytes.
- DATA:
  - in_ready=1 continuously; no back-pressure.
  - Bytes assemble little-endian into a word.
  - On the edge accepting the 4th byte of a word, register rom_wdata=assembled word, rom_waddr=word index, rom_we=1. rom_we is therefore high for exactly the following cycle.
  - Word index increments after each write.
  - After the N-th word is accepted -> DONE on the same edge; in_ready drops the next cycle.
  - The final rom_we pulse is still emitted in the first DONE cycle.
- DONE:
  - in_ready=0.
  - cpu_hold=0 and done=1, both registered, taking effect the cycle after the final write pulse. The CPU never runs while a write is outstanding.
  - start -> LEN, with cpu_hold=1 and done=0 on the same edge (reload).
- ERR:
  - in_ready=0, err=1, cpu_hold=1.
  - start -> LEN, clearing err.
- start is ignored in LEN and DATA.
- Gaps in in_valid are allowed anywhere; partial-word byte count is held across gaps.
- Back-to-back writes: words may arrive every 4 cycles minimum. rom_we never asserts on consecutive cycles.
- rst mid-load:
  - Returns to IDLE and outputs to reset values.
  - Partially written ROM contents are not cleared.
  - cpu_hold stays 1.
- Addresses: rom_waddr never exceeds N-1 <= DEPTH-1, so there is no wrap-around.

Test Plan:
- Reset then idle: hold rst 2 cycles; drive in_valid=1 with no start -> in_ready=0, cpu_hold=1, done=err=rom_we=0 for 20 cycles.
- Basic load: start, stream 02 00 00 00, 13 05 10 00, 73 00 10 00 with in_valid continuous -> exactly two rom_we pulses:
  - addr 0 data 0x00100513;
  - addr 1 data 0x00100073.
  - Then done=1 and cpu_hold=0 one cycle after the second pulse.
- Gapped stream: same image with in_valid toggled 1/0 each cycle -> identical writes and values; rom_we pulses never adjacent.
- Length errors:
  - Length 0 -> err=1, cpu_hold=1, no rom_we.
  - Length DEPTH+1 (0x00001001 at default) -> err=1.
  - Then start followed by a valid 1-word image -> err clears and the load completes.
- Reset mid-load: rst asserted after 6 data bytes of a 3-word image -> IDLE, cpu_hold=1, rom_we=0. The restarted load of a 1-word image writes addr 0 and completes.
- Reload: after DONE, assert start -> cpu_hold=1 and done=0 the next cycle. A new 1-word image 0xDEADBEEF (bytes EF BE AD DE) is written to addr 0.

Source files
------------

// File: rtl/rom_loader_if.sv
// Byte-stream sink and ROM write port of the program loader.
// The loader takes the slave side; the byte source / ROM side takes the master side.
interface rom_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  rom_we;
    logic [ADDR_WIDTH-1:0] rom_waddr;
    logic [31:0]           rom_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, rom_we, rom_waddr, rom_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, rom_we, rom_waddr, rom_wdata
    );
endinterface

// File: rtl/rom_loader.sv
// Program loader: takes a length-prefixed little-endian byte stream, writes one ROM word
// per four bytes and keeps the CPU in reset until the whole image has been written.
module rom_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    rom_loader_if.slave  bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [31:0]         DEPTH_W = 32'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [2:0]            state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic        accept;
    logic [31:0] asm_word;

    assign bus.in_ready  = (state_q == S_LEN) || (state_q == S_DATA);
    assign accept        = bus.in_valid && bus.in_ready;
    // Bytes shift in from the top, so after four bytes the first one sits in bits 7:0.
    assign asm_word      = {bus.in_data, shift_q};

    assign bus.rom_we    = rom_we_q;
    assign bus.rom_waddr = waddr_q;
    assign bus.rom_wdata = wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        rom_we_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Release lands one cycle after the last write pulse, which is still in flight
                // during the first DONE cycle.
                if (state_q == S_DONE) begin
                    cpu_hold_d = 1'b0;
                    done_d     = 1'b1;
                end
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    waddr_d    = '0;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    shift_d    = asm_word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (asm_word == 32'd0 || asm_word > DEPTH_W) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_DATA;
                            len_d   = asm_word[ADDR_WIDTH:0];
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d    = asm_word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        rom_we_d   = 1'b1;
                        waddr_d    = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d    = asm_word;
                        word_cnt_d = word_cnt_q + CNT_ONE;
                        if (word_cnt_q + CNT_ONE == len_q) state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            rom_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            rom_we_q   <= rom_we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule
